// File: rtl/pmem_burst_responder_pkg.sv
// pmem_burst_responder_pkg: shared burst geometry, responder state and op encodings.
package pmem_burst_responder_pkg;

    localparam int BURST_LEN  = 4;
    localparam int LINE_BYTES = 32;
    localparam int LINE_WIDTH = 256;
    localparam int BEAT_WIDTH = LINE_WIDTH / BURST_LEN;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BURST,
        ST_DONE
    } resp_state_e;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_e;

    function automatic logic [BEAT_WIDTH-1:0] beat_slice(input logic [LINE_WIDTH-1:0] line,
                                                         input logic [1:0] beat);
        return line[{beat, 6'd0} +: BEAT_WIDTH];
    endfunction

endpackage

// File: rtl/pmem_line_array.sv
// pmem_line_array: DEPTH_LINES x 256-bit line store, one asynchronous line read port
// and one 64-bit beat-select write port sharing the same line index. Not reset.
module pmem_line_array
    import pmem_burst_responder_pkg::*;
#(
    parameter int DEPTH_LINES = 64,
    parameter int AW          = $clog2(DEPTH_LINES)
) (
    input  logic                  clk,
    input  logic [AW-1:0]         line_idx,
    input  logic                  wr_en,
    input  logic [1:0]            wr_beat,
    input  logic [BEAT_WIDTH-1:0] wr_data,
    output logic [LINE_WIDTH-1:0] rd_line
);

    logic [LINE_WIDTH-1:0] lines_q [DEPTH_LINES];

    always_ff @(posedge clk) begin
        if (wr_en) lines_q[line_idx][{wr_beat, 6'd0} +: BEAT_WIDTH] <= wr_data;
    end

    assign rd_line = lines_q[line_idx];

endmodule

// File: rtl/pmem_burst_responder.sv
// pmem_burst_responder: fixed-latency 4-beat burst memory responder with a sticky
// protocol checker; all outputs registered.
module pmem_burst_responder
    import pmem_burst_responder_pkg::*;
#(
    parameter int LATENCY     = 10,
    parameter int DEPTH_LINES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [63:0] mem_wdata,
    output logic [63:0] mem_rdata,
    output logic        mem_resp,
    output logic        proto_err
);

    localparam int AW = $clog2(DEPTH_LINES);
    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    resp_state_e state_q, state_d;
    op_e         op_q, op_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  beat_q, beat_d;
    logic [31:0] addr_q, addr_d;
    logic [63:0] rdata_q, rdata_d;
    logic        resp_q, resp_d;
    logic        err_q, err_d;
    logic        wr_en;
    logic        req_held;
    logic [LINE_WIDTH-1:0] rd_line;

    pmem_line_array #(.DEPTH_LINES(DEPTH_LINES)) u_lines (
        .clk      (clk),
        .line_idx (addr_q[5 +: AW]),
        .wr_en    (wr_en),
        .wr_beat  (beat_q),
        .wr_data  (mem_wdata),
        .rd_line  (rd_line)
    );

    // The initiator must keep the same op and address asserted until the last beat.
    assign req_held = (op_q == OP_WRITE ? (mem_write && !mem_read) : (mem_read && !mem_write))
                      && (mem_address == addr_q);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        err_d   = err_q;
        resp_d  = 1'b0;
        rdata_d = '0;
        wr_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_read && mem_write) begin
                    err_d = 1'b1;
                end else if (mem_read || mem_write) begin
                    state_d = ST_WAIT;
                    addr_d  = mem_address;
                    op_d    = mem_write ? OP_WRITE : OP_READ;
                    cnt_d   = CNT_INIT;
                end
            end
            ST_WAIT: begin
                if (!req_held) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_BURST;
                    beat_d  = '0;
                    resp_d  = 1'b1;
                    rdata_d = op_q == OP_READ ? beat_slice(rd_line, 2'd0) : '0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_BURST: begin
                if (!req_held) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    beat_d  = '0;
                end else begin
                    wr_en   = op_q == OP_WRITE;
                    beat_d  = beat_q + 2'd1;
                    state_d = beat_q == 2'd3 ? ST_DONE : ST_BURST;
                    resp_d  = beat_q != 2'd3;
                    rdata_d = (beat_q != 2'd3 && op_q == OP_READ) ?
                              beat_slice(rd_line, beat_q + 2'd1) : '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_READ;
            cnt_q   <= '0;
            beat_q  <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
            resp_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_resp  = resp_q;
    assign proto_err = err_q;

endmodule
